fir_decimator: RTL

FIR_DECIMATOR -- requirements
Module: fir_decimator

---
 rtl/fir_decimator.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fir_decimator.sv
// Block-averaging decimator behind a FIR stage. It sums N = 2**DEC_LOG2 valid samples and
// emits the scaled sum into a 4-entry show-ahead FIFO. Optional macro: FIR_DEC_ROUND_EN.
module fir_decimator #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEC_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*WIDTH-1:0]   fir_out,
    input  logic                 in_valid,
    output logic [2*WIDTH-1:0]   dec_out,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic                 overflow,
    input  logic                 clr_ovf,
    output logic [2:0]           fill
);

    localparam int unsigned DataW   = 2 * WIDTH;
    localparam int unsigned AccW    = DataW + DEC_LOG2;
    localparam int unsigned PhaseW  = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
    localparam int unsigned NumSmp  = 1 << DEC_LOG2;
    localparam int unsigned Depth   = 4;

    localparam logic [PhaseW-1:0] LastPhase = PhaseW'(NumSmp - 1);

`ifdef FIR_DEC_ROUND_EN
    // Half an output LSB; zero when DEC_LOG2 == 0 so the pass-through case is exact.
    localparam logic [AccW:0] RoundAdd = (AccW + 1)'((2 ** DEC_LOG2) >> 1);
`else
    localparam logic [AccW:0] RoundAdd = '0;
`endif

    // ------------------------------------------------------------------
    // Accumulate / decimate
    // ------------------------------------------------------------------
    logic [PhaseW-1:0] phase_q, phase_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [AccW:0]     sum_full;
    logic [AccW:0]     sum_shift;
    logic [DataW-1:0]  result;
    logic              last_smp;

    assign last_smp = in_valid && (phase_q == LastPhase);

    always_comb begin
        sum_full  = {1'b0, acc_q} + (AccW + 1)'(fir_out) + RoundAdd;
        sum_shift = sum_full >> DEC_LOG2;
        // The bound on N samples keeps this clamp unreachable; it guards odd parameterisations.
        if (sum_shift[AccW:DataW] != '0) begin
            result = '1;
        end else begin
            result = sum_shift[DataW-1:0];
        end
    end

    always_comb begin
        phase_d = phase_q;
        acc_d   = acc_q;
        if (in_valid) begin
            if (last_smp) begin
                phase_d = '0;
                acc_d   = '0;
            end else begin
                phase_d = phase_q + 1'b1;
                acc_d   = acc_q + AccW'(fir_out);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            acc_q   <= '0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [DataW-1:0] mem_q [Depth];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       fill_q, fill_d;
    logic             ovf_q, ovf_d;
    logic             full, empty;
    logic             do_pop, do_push, drop;

    assign full  = (fill_q == 3'(Depth));
    assign empty = (fill_q == 3'd0);

    // A pop frees the slot in the same edge, so a full FIFO can still take a push.
    assign do_pop  = !empty && dec_ready;
    assign do_push = last_smp && (!full || do_pop);
    assign drop    = last_smp && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        unique case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + 3'd1;
            2'b01:   fill_d = fill_q - 3'd1;
            default: fill_d = fill_q;
        endcase
    end

    // A new drop wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    assign dec_out   = empty ? '0 : mem_q[rd_ptr_q];
    assign dec_valid = !empty;
    assign overflow  = ovf_q;
    assign fill      = fill_q;

endmodule
